// File: rtl/bus_responder.sv
// Single-cycle data-bus target: word-addressed RAM plus an MMIO window (console FIFO, status, cycle counter).
// Define BUS_RESPONDER_CYCLE_COUNTER_EN to build the 64-bit cycle counter; otherwise CYCLE_LO/HI read 0.
module bus_responder #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_wr_data,
    input  logic [2:0]  bus_write_length,
    input  logic        bus_wr_enable,
    output logic [31:0] bus_read_data,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;

    logic [31:0]        ram [RAM_WORDS];
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               misalign_err;
    logic               overflow_err;

    logic [1:0]        byte_off;
    logic [1:0]        mmio_off;
    logic [RAM_AW-1:0] ram_index;
    logic              ram_hit;
    logic              mmio_hit;
    logic              len_legal;
    logic              legal_wr;
    logic              illegal_wr;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_data;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              status_wr;
    logic              full;
    logic              empty;
    logic [31:0]       status_word;
    logic [31:0]       cycle_lo;
    logic [31:0]       cycle_hi;
    logic [31:0]       sel_word;

    assign byte_off  = bus_address[1:0];
    assign mmio_off  = bus_address[3:2];
    assign ram_index = bus_address[RAM_AW+1:2];
    assign ram_hit   = {2'b00, bus_address[31:2]} < 32'(RAM_WORDS);
    assign mmio_hit  = !ram_hit && (bus_address[31:4] == MMIO_BASE[31:4]);

    // Width/alignment legality, and the byte lanes a legal store touches
    always_comb begin
        len_legal = 1'b0;
        lane_mask = 4'b0000;
        lane_data = bus_wr_data;
        case (bus_write_length)
            3'b000: begin
                len_legal = 1'b1;
                lane_mask = 4'b0001 << byte_off;
                lane_data = {4{bus_wr_data[7:0]}};
            end
            3'b001: begin
                len_legal = !byte_off[0];
                lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus_wr_data[15:0]}};
            end
            3'b010: begin
                len_legal = (byte_off == 2'b00);
                lane_mask = 4'b1111;
            end
            default: len_legal = 1'b0;
        endcase
    end

    assign legal_wr   = bus_wr_enable && len_legal && (ram_hit || mmio_hit);
    assign illegal_wr = bus_wr_enable && !len_legal && (ram_hit || mmio_hit);

    assign full          = (count == CNT_W'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign console_valid = !empty;
    assign console_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    assign pop       = console_valid && console_ready;
    assign push_req  = legal_wr && mmio_hit && (mmio_off == 2'd0);
    assign push_ok   = push_req && (!full || pop);
    assign status_wr = legal_wr && mmio_hit && (mmio_off == 2'd1);

    always_ff @(posedge clk) begin
        if (!reset && legal_wr && ram_hit) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_mask[l]) ram[ram_index][8*l +: 8] <= lane_data[8*l +: 8];
            end
        end
    end

    // FIFO pointers and sticky flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= bus_wr_data[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;

            if (illegal_wr)
                misalign_err <= 1'b1;
            else if (status_wr && lane_mask[0] && lane_data[2])
                misalign_err <= 1'b0;

            if (push_req && !push_ok)
                overflow_err <= 1'b1;
            else if (status_wr && lane_mask[0] && lane_data[3])
                overflow_err <= 1'b0;
        end
    end

`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
    logic [63:0] cycle;

    always_ff @(posedge clk) begin
        if (reset) cycle <= '0;
        else       cycle <= cycle + 64'd1;
    end

    assign cycle_lo = cycle[31:0];
    assign cycle_hi = cycle[63:32];
`else
    assign cycle_lo = '0;
    assign cycle_hi = '0;
`endif

    assign status_word = {16'h0000, 8'(count), 4'b0000, overflow_err, misalign_err, empty, full};

    always_comb begin
        sel_word = '0;
        if (ram_hit) begin
            sel_word = ram[ram_index];
        end else if (mmio_hit) begin
            case (mmio_off)
                2'd1:    sel_word = status_word;
                2'd2:    sel_word = cycle_lo;
                2'd3:    sel_word = cycle_hi;
                default: sel_word = '0;
            endcase
        end
    end

    assign bus_read_data = sel_word >> {byte_off, 3'b000};

endmodule
